// File: rtl/rc4_pkg.sv
// rc4_pkg: shared key width, key type and search FSM states for the RC4 key-search cores.
package rc4_pkg;
    localparam int KEY_WIDTH = 24;
    typedef logic [KEY_WIDTH-1:0] key_t;
    typedef enum logic [2:0] {LAUNCH, WAIT, NEXT, FOUND, EXHAUSTED, HALTED} search_state_t;
endpackage

// File: rtl/key_range_counter.sv
// key_range_counter: candidate key register with a one-bit-wider adder so the last-key test never wraps.
module key_range_counter
    import rc4_pkg::*;
#(
    parameter key_t KEY_START = '0,
    parameter key_t KEY_STEP  = key_t'(1),
    parameter key_t KEY_END   = '1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_advance,
    output key_t o_key,
    output logic o_is_last
);
    key_t r_key;
    logic [KEY_WIDTH:0] w_sum;
    assign w_sum     = {1'b0, r_key} + {1'b0, KEY_STEP};
    assign o_is_last = w_sum > {1'b0, KEY_END};
    assign o_key     = r_key;
    always_ff @(posedge clk) begin
        if (reset)
            r_key <= KEY_START;
        else if (i_advance)
            r_key <= w_sum[KEY_WIDTH-1:0];
    end
endmodule

// File: rtl/key_search_controller.sv
// key_search_controller: walks a strided key range, launching the decrypt core per candidate
// and reporting a found key, range exhaustion or a master halt.
module key_search_controller
    import rc4_pkg::*;
#(
    parameter key_t KEY_START = '0,
    parameter key_t KEY_STEP  = key_t'(1),
    parameter key_t KEY_END   = '1
) (
    input  logic clk,
    input  logic reset,
    input  logic stop,
    output logic core_start,
    output key_t core_key,
    input  logic core_done,
    input  logic core_valid,
    output logic success,
    output logic fail,
    output key_t found_key,
    output logic busy
);
    localparam bit EMPTY = KEY_START > KEY_END;
    search_state_t r_state, w_next;
    logic w_is_last, w_advance, w_start, w_found, w_busy;
    logic r_start, r_success, r_fail, r_busy;
    key_t r_found_key;

    key_range_counter #(.KEY_START(KEY_START), .KEY_STEP(KEY_STEP), .KEY_END(KEY_END)) u_counter (
        .clk      (clk),
        .reset    (reset),
        .i_advance(w_advance),
        .o_key    (core_key),
        .o_is_last(w_is_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= LAUNCH;
            r_start     <= 1'b0;
            r_success   <= 1'b0;
            r_fail      <= 1'b0;
            r_busy      <= 1'b0;
            r_found_key <= '0;
        end else begin
            r_state   <= w_next;
            r_start   <= w_start;
            r_success <= w_next == FOUND;
            r_fail    <= w_next == EXHAUSTED;
            r_busy    <= w_busy;
            if (w_found)
                r_found_key <= core_key;
        end
    end

    // A local match wins over a simultaneous halt so the master still learns the key.
    always_comb begin
        w_next = r_state;
        case (r_state)
            LAUNCH:  w_next = stop ? HALTED : (EMPTY ? EXHAUSTED : WAIT);
            WAIT:    w_next = (core_done && core_valid) ? FOUND :
                              stop ? HALTED :
                              core_done ? (w_is_last ? EXHAUSTED : NEXT) : WAIT;
            NEXT:    w_next = stop ? HALTED : LAUNCH;
            default: w_next = r_state;
        endcase
    end

    always_comb begin
        w_start   = r_state == LAUNCH && w_next == WAIT;
        w_advance = r_state == NEXT && w_next == LAUNCH;
        w_found   = r_state == WAIT && w_next == FOUND;
        w_busy    = w_next inside {LAUNCH, WAIT, NEXT};
    end

    assign core_start = r_start;
    assign success    = r_success;
    assign fail       = r_fail;
    assign busy       = r_busy;
    assign found_key  = r_found_key;
endmodule
